// File: rtl/dlp_pkg.sv
// Shared constants, pixel type and FSM encoding for the display prefetch path.
package dlp_pkg;
  localparam int DW    = 24;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int BURST = 8;
  localparam int PRIME = 32;

  typedef logic [DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_PREFETCH = 2'd0,
    ST_STREAM   = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;
endpackage

// File: rtl/pf_fifo_mem.sv
// DEPTH x DW dual-port pixel storage: synchronous write, registered read.
module pf_fifo_mem
  import dlp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data
);
  pixel_t mem_q [DEPTH];
  pixel_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Output register holds the last popped pixel until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/pixel_prefetch_fifo.sv
// Credit-controlled DDR2 burst prefetch FIFO feeding the pixel generator; flushes on eov.
module pixel_prefetch_fifo
  import dlp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eov,
  input  logic        load_ready,
  output pixel_t      load_data,
  output logic        load_valid,
  output logic        local_rd_req,
  input  logic        local_rd_ready,
  input  pixel_t      local_rd_data,
  input  logic        local_rd_valid,
  output logic [AW:0] level,
  output logic        primed,
  output logic        underflow,
  output logic        overflow
);
  localparam int SW = AW + 3;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d, outstanding_q, outstanding_d;
  logic          load_valid_q, load_valid_d, primed_q, primed_d;
  logic          underflow_q, underflow_d, overflow_q, overflow_d;
  logic          run_q;
  logic          full, empty, in_flush, accept, push, pop;
  logic [SW-1:0] credit_sum;

  assign full       = (level_q == (AW+1)'(DEPTH));
  assign empty      = (level_q == '0);
  assign in_flush   = (state_q == ST_FLUSH);
  assign credit_sum = SW'(level_q) + SW'(outstanding_q) + SW'(BURST);
  // run_q keeps the request low while reset is asserted and until the first clock after it.
  assign local_rd_req = run_q && !in_flush && (credit_sum <= SW'(DEPTH));
  assign accept       = local_rd_req && local_rd_ready;
  assign push         = local_rd_valid && !in_flush && !full;
  assign pop          = (state_q == ST_STREAM) && load_ready && !empty && !eov;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    outstanding_d = outstanding_q;
    primed_d      = primed_q;
    underflow_d   = underflow_q;
    overflow_d    = overflow_q;
    load_valid_d  = pop;

    if (accept) outstanding_d = outstanding_d + (AW+1)'(BURST);
    // A stray return with nothing owed must not wrap the credit counter.
    if (local_rd_valid && (outstanding_q != '0)) outstanding_d = outstanding_d - (AW+1)'(1);
    if (local_rd_valid && !in_flush && full) overflow_d = 1'b1;
    if ((state_q == ST_STREAM) && load_ready && empty && !eov) underflow_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (pop && !push) level_d = level_q - (AW+1)'(1);

    case (state_q)
      ST_PREFETCH: begin
        if (!eov && (level_d >= (AW+1)'(PRIME))) begin
          state_d  = ST_STREAM;
          primed_d = 1'b1;
        end
      end
      ST_STREAM: ;
      ST_FLUSH: begin
        if (outstanding_d == '0) state_d = ST_PREFETCH;
      end
      default: state_d = ST_PREFETCH;
    endcase

    if (eov && !in_flush) begin
      state_d  = ST_FLUSH;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      primed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PREFETCH;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      outstanding_q <= '0;
      load_valid_q  <= 1'b0;
      primed_q      <= 1'b0;
      underflow_q   <= 1'b0;
      overflow_q    <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      outstanding_q <= outstanding_d;
      load_valid_q  <= load_valid_d;
      primed_q      <= primed_d;
      underflow_q   <= underflow_d;
      overflow_q    <= overflow_d;
      run_q         <= 1'b1;
    end
  end

  pf_fifo_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (local_rd_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (load_data)
  );

  assign load_valid = load_valid_q;
  assign level      = level_q;
  assign primed     = primed_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// Directed scoreboard bench for pixel_prefetch_fifo with a fixed-latency DDR return model.
module tb_pixel_prefetch_fifo;
  import dlp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, eov, load_ready, local_rd_ready, local_rd_valid;
  pixel_t      local_rd_data, load_data;
  logic        load_valid, local_rd_req, primed, underflow, overflow;
  logic [AW:0] level;

  int     checks = 0, passed = 0, cyc = 0, accepts = 0, last_rel = 0;
  int     discard = 0, pix_cnt = 1, valid_cnt = 0;
  bit     inject = 1'b0;
  int     ret_q[$];
  pixel_t exp_q[$];

  always #5 clk = ~clk;

  pixel_prefetch_fifo dut (
    .clk(clk), .rst_n(rst_n), .eov(eov), .load_ready(load_ready),
    .load_data(load_data), .load_valid(load_valid), .local_rd_req(local_rd_req),
    .local_rd_ready(local_rd_ready), .local_rd_data(local_rd_data),
    .local_rd_valid(local_rd_valid), .level(level), .primed(primed),
    .underflow(underflow), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive DDR return, note accept, advance, then score any popped pixel.
  task automatic tick();
    bit     do_ret;
    int     base;
    pixel_t e;
    do_ret = inject || (ret_q.size() > 0 && ret_q[0] <= cyc);
    local_rd_valid = do_ret;
    local_rd_data  = '0;
    if (inject) begin
      local_rd_data = 24'hDEAD00;
    end else if (do_ret) begin
      void'(ret_q.pop_front());
      local_rd_data = pixel_t'(pix_cnt);
      pix_cnt++;
      if (discard > 0) discard--;
      else exp_q.push_back(local_rd_data);
    end
    if (eov) begin
      exp_q.delete();
      discard = ret_q.size();
    end
    if (local_rd_req && local_rd_ready) begin
      accepts++;
      base = (cyc + 4 > last_rel + 1) ? cyc + 4 : last_rel + 1;
      for (int k = 0; k < BURST; k++) ret_q.push_back(base + k);
      last_rel = base + BURST - 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (load_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("load_data", load_data, e);
      end
    end
  endtask

  initial begin
    int n, minlvl, lvl_prime, vstart, flush_req;
    bit seen;
    pixel_t first_new;
    rst_n = 1'b0; eov = 1'b0; load_ready = 1'b0; local_rd_ready = 1'b0;
    local_rd_valid = 1'b0; local_rd_data = '0;
    #1;
    chk("rst_load_valid", load_valid, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_req", local_rd_req, 0);
    chk("rst_level", level, 0);
    chk("rst_primed", primed, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Prefetch: fill from empty to the credit limit
    local_rd_ready = 1'b1;
    seen = 1'b0; lvl_prime = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (primed && !seen) begin seen = 1'b1; lvl_prime = int'(level); end
    end
    chk("prefetch_accepts", accepts, 8);
    chk("prefetch_level", level, 64);
    chk("primed_level", lvl_prime, 32);
    chk("prefetch_req_stop", local_rd_req, 0);

    // Continuous streaming
    load_ready = 1'b1;
    minlvl = 64; vstart = valid_cnt;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int'(level) < minlvl) minlvl = int'(level);
    end
    chk("stream_valid_cnt", valid_cnt - vstart, 100);
    chk("stream_level_pos", minlvl > 0, 1);
    chk("stream_underflow", underflow, 0);

    // DDR stall drains the FIFO
    local_rd_ready = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    chk("stall_level", level, 0);
    chk("stall_underflow", underflow, 1);
    chk("stall_valid", load_valid, 0);
    local_rd_ready = 1'b1; load_ready = 1'b0;
    n = 0; while (level != 64 && n < 200) begin tick(); n++; end
    chk("recover_level", level, 64);
    load_ready = 1'b1; vstart = valid_cnt;
    for (int i = 0; i < 20; i++) tick();
    chk("recover_valid_cnt", valid_cnt - vstart, 20);

    // Flush on eov with 16 pixels outstanding
    local_rd_ready = 1'b0;
    n = 0; while (!(level == 0 && ret_q.size() == 0) && n < 300) begin tick(); n++; end
    load_ready = 1'b0; local_rd_ready = 1'b1;
    n = 0; while (ret_q.size() != 16 && n < 20) begin tick(); n++; end
    eov = 1'b1; load_ready = 1'b1; local_rd_ready = 1'b0;
    tick();
    eov = 1'b0; load_ready = 1'b0; local_rd_ready = 1'b1;
    chk("flush_level", level, 0);
    chk("flush_primed", primed, 0);
    chk("flush_eov_valid", load_valid, 0);
    flush_req = 0; n = 0;
    while (ret_q.size() > 0 && n < 60) begin
      if (local_rd_req) flush_req++;
      tick(); n++;
    end
    chk("flush_no_req", flush_req, 0);
    chk("flush_discarded", exp_q.size(), 0);
    first_new = pixel_t'(pix_cnt);
    n = 0; while (!primed && n < 100) begin tick(); n++; end
    chk("reprime_level", level, 32);
    load_ready = 1'b1;
    tick();
    chk("newframe_valid", load_valid, 1);
    chk("newframe_first", load_data, first_new);

    // Accept, return and pop in one cycle at level 40
    load_ready = 1'b0; local_rd_ready = 1'b1;
    n = 0; while (!(level == 64 && ret_q.size() == 0) && n < 200) begin tick(); n++; end
    local_rd_ready = 1'b0; load_ready = 1'b1;
    n = 0; while (level > 41 && n < 40) begin tick(); n++; end
    chk("pre_level41", level, 41);
    local_rd_ready = 1'b1;
    tick();
    local_rd_ready = 1'b0; load_ready = 1'b0;
    n = 0; while (!(ret_q.size() > 0 && ret_q[0] <= cyc) && n < 10) begin tick(); n++; end
    chk("triple_req_ok", local_rd_req, 1);
    local_rd_ready = 1'b1; load_ready = 1'b1;
    tick();
    chk("triple_level", level, 40);
    local_rd_ready = 1'b0; load_ready = 1'b0;
    n = 0; while (ret_q.size() > 0 && n < 40) begin tick(); n++; end
    chk("triple_drain_level", level, 55);
    load_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    load_ready = 1'b0; local_rd_ready = 1'b1;
    tick();
    local_rd_ready = 1'b0;
    chk("credit_edge_req", local_rd_req, 1);

    // Forced return while full
    local_rd_ready = 1'b1;
    n = 0; while (!(level == 64 && ret_q.size() == 0) && n < 200) begin tick(); n++; end
    local_rd_ready = 1'b0;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 64);
    load_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Asynchronous reset mid-burst
    local_rd_ready = 1'b1;
    n = 0; while (ret_q.size() == 0 && n < 40) begin tick(); n++; end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_load_valid", load_valid, 0);
    chk("arst_load_data", load_data, 0);
    chk("arst_req", local_rd_req, 0);
    chk("arst_level", level, 0);
    chk("arst_primed", primed, 0);
    chk("arst_underflow", underflow, 0);
    chk("arst_overflow", overflow, 0);
    ret_q.delete(); exp_q.delete();
    local_rd_ready = 1'b0; load_ready = 1'b0; local_rd_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
